if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage between the PC register and the IF/ID boundary. Takes the PC stage's `pc`/`ce`, runs a request/acknowledge read against instruction memory and presents the fetched word with its PC to decode. Requests a PC hold while a fetch is outstanding, kills wrong-path fetches on branch, and buffers a returned word while decode is stalled.

## Interface
- `NOP_INST`, default 32'h0000_0000: value driven on `id_inst_o` when no valid instruction is presented.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `pc_i` in 32: fetch address from PC stage.
- `ce_i` in 1: PC stage enable; no fetch is issued while low.
- `flush_i` in 1: branch taken this cycle; same signal as the PC stage's branch flag.
- `stall_i` in 1: decode cannot accept an instruction this cycle.
- `stall_req_o` out 1: hold request to the PC stage's stop input (combinational).
- `imem_req_o` out 1: memory read request, registered.
- `imem_addr_o` out 32: memory read address, registered, stable while `imem_req_o` is high.
- `imem_ack_i` in 1: read data valid; may be high in the first request cycle.
- `imem_rdata_i` in 32: read data, valid when `imem_ack_i` is high.
- `id_pc_o` out 32: PC of the presented instruction.
- `id_inst_o` out 32: presented instruction.
- `id_valid_o` out 1: `id_pc_o`/`id_inst_o` hold a live instruction.
- `perf_fetch_o` out 32, `perf_wait_o` out 32: present only with `IF_FETCH_PERF_EN`.

## Operation
- States: IDLE, WAIT (live request), DROP (killed request still outstanding), HOLD (word buffered, decode stalled).
- Issue: in IDLE, and in WAIT on an accepted ack, when `ce_i && !flush_i && !stall_i`: `imem_addr_o <= pc_i`, `imem_req_o <= 1`, go to WAIT. Otherwise `imem_req_o <= 0`.
- A request is never withdrawn. `imem_req_o` and `imem_addr_o` hold until `imem_ack_i`.
- WAIT with ack, no flush, `!stall_i`: `id_inst_o <= imem_rdata_i`, `id_pc_o <= imem_addr_o`, `id_valid_o <= 1`. Then issue as above, or go to IDLE.
- WAIT with ack, no flush, `stall_i`: capture the word and address in the hold buffer, go to HOLD. ID registers are unchanged.
- HOLD: when `stall_i` falls, move the hold buffer to the ID registers with `id_valid_o <= 1`, then go to IDLE.
- WAIT/IDLE with `!stall_i` and no new word: `id_valid_o <= 0`, `id_inst_o <= NOP_INST`.
- Flush has priority over every other event:
  - `id_valid_o <= 0`, `id_inst_o <= NOP_INST`; the hold buffer is discarded.
  - WAIT without ack goes to DROP. WAIT with ack discards that data and goes to IDLE. IDLE and HOLD go to IDLE.
  - No issue happens in the flush cycle.
- DROP: on `imem_ack_i`, discard data, `imem_req_o <= 0`, go to IDLE. A flush while in DROP stays in DROP.
- `stall_req_o = !flush_i && (stall_i || (WAIT && !imem_ack_i) || DROP || HOLD)`. It is forced low in the flush cycle so the PC stage loads the branch target.

## Timing
- Reset values: state IDLE; `imem_req_o` 0; `imem_addr_o` 32'h8000_0000; `id_pc_o` 32'h8000_0000; `id_inst_o` `NOP_INST`; `id_valid_o` 0; perf counters 0.
- A reset assertion mid-request drops the request immediately. Memory tolerates the abandoned read.
- Latency: issue at edge N, ack in cycle N+k (k ≥ 0 wait cycles), instruction valid at edge N+k+1.
- Zero-wait memory gives one instruction per cycle and `stall_req_o` stays low.
- The PC stage advances only on edges where `stall_req_o` is low, so `pc_i` equals the next sequential address at every issue.
- After a flush, the branch target is issued on the first IDLE cycle: the edge after the flush if nothing is outstanding, otherwise the edge after the DROP ack.

## Configuration
- `IF_FETCH_PERF_EN` defined:
  - `perf_fetch_o` increments on every edge where `id_valid_o` is loaded with 1.
  - `perf_wait_o` increments every cycle in WAIT or DROP with `imem_ack_i` low.
  - Both are 32-bit, wrap at 2^32, and are reset to 0.
- `IF_FETCH_PERF_EN` undefined: both ports and their counters are absent; the remaining behaviour is identical.

## Test plan
- Zero-wait ack, `pc_i` stepping 0x8000_0000, 0x8000_0004, 0x8000_0008 -> three consecutive valid words with matching `id_pc_o`; `stall_req_o` never high.
- Two-cycle ack delay on fetch at 0x8000_0000 -> `stall_req_o` high for two cycles; `imem_addr_o` stable; word valid one edge after the ack.
- Flush while WAIT on 0x8000_0010 with ack three cycles later -> `stall_req_o` low in the flush cycle; stale data dropped; next issue address 0x8000_0100 (branch target); no valid word for 0x8000_0010.
- `stall_i` high when the ack for 0x8000_0020 arrives, held four cycles -> ID registers unchanged; `stall_req_o` high; word presented on the edge after `stall_i` falls.
- `rst` asserted during WAIT -> `imem_req_o` 0 immediately, `id_valid_o` 0, `imem_addr_o` 0x8000_0000; clean restart after release.
- With `IF_FETCH_PERF_EN`: five fetches each with one wait cycle -> `perf_fetch_o`=5, `perf_wait_o`=5.

Source files
------------

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage issuing req/ack reads from the PC stage address and presenting words to decode.
//   clk, rst (async active-low); pc_i/ce_i from the PC stage; flush_i branch kill; stall_i decode stall;
//   stall_req_o PC hold (combinational); imem_req_o/imem_addr_o registered read request, imem_ack_i/imem_rdata_i response;
//   id_pc_o/id_inst_o/id_valid_o registered instruction to decode.
//   Optional IF_FETCH_PERF_EN adds perf_fetch_o (words presented) and perf_wait_o (cycles waiting on ack).
module if_fetch #(
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        ce_i,
  input  logic        flush_i,
  input  logic        stall_i,
  output logic        stall_req_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_o,
  output logic [31:0] perf_wait_o
`endif
);
  typedef enum logic [1:0] {IDLE, WAIT, DROP, HOLD} state_t;
  state_t      r_state;
  logic        r_req;
  logic [31:0] r_addr;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_inst;
  logic        r_id_valid;
  logic [31:0] r_hold_pc;
  logic [31:0] r_hold_inst;
  logic        w_take;
  logic        w_issue;
  assign w_take      = r_state == WAIT && imem_ack_i;
  assign w_issue     = ce_i && !stall_i;
  // Forced low on flush so the PC stage loads the branch target that cycle.
  assign stall_req_o = !flush_i && (stall_i || (r_state == WAIT && !imem_ack_i) || r_state == DROP || r_state == HOLD);
  assign imem_req_o  = r_req;
  assign imem_addr_o = r_addr;
  assign id_pc_o     = r_id_pc;
  assign id_inst_o   = r_id_inst;
  assign id_valid_o  = r_id_valid;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_req       <= 1'b0;
      r_addr      <= 32'h8000_0000;
      r_id_pc     <= 32'h8000_0000;
      r_id_inst   <= NOP_INST;
      r_id_valid  <= 1'b0;
      r_hold_pc   <= 32'h8000_0000;
      r_hold_inst <= NOP_INST;
    end else if (flush_i) begin
      // An unanswered request cannot be withdrawn, so it is drained in DROP.
      r_state    <= (r_req && !imem_ack_i) ? DROP : IDLE;
      r_req      <= r_req && !imem_ack_i;
      r_id_valid <= 1'b0;
      r_id_inst  <= NOP_INST;
    end else begin
      case (r_state)
        DROP: if (imem_ack_i) begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
        HOLD: if (!stall_i) begin
          r_state    <= IDLE;
          r_id_pc    <= r_hold_pc;
          r_id_inst  <= r_hold_inst;
          r_id_valid <= 1'b1;
        end
        default: begin
          if (!stall_i) begin
            r_id_valid <= w_take;
            r_id_inst  <= w_take ? imem_rdata_i : NOP_INST;
            r_id_pc    <= w_take ? r_addr : r_id_pc;
          end
          if (w_take && stall_i) begin
            r_state     <= HOLD;
            r_req       <= 1'b0;
            r_hold_pc   <= r_addr;
            r_hold_inst <= imem_rdata_i;
          end else if (w_take || r_state == IDLE) begin
            r_state <= w_issue ? WAIT : IDLE;
            r_req   <= w_issue;
            r_addr  <= w_issue ? pc_i : r_addr;
          end
        end
      endcase
    end
  end
`ifdef IF_FETCH_PERF_EN
  logic        w_load;
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_wait;
  assign w_load       = !flush_i && !stall_i && (w_take || r_state == HOLD);
  assign perf_fetch_o = r_perf_fetch;
  assign perf_wait_o  = r_perf_wait;
  // r_req is high exactly in WAIT and DROP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_fetch <= 32'd0;
      r_perf_wait  <= 32'd0;
    end else begin
      r_perf_fetch <= r_perf_fetch + 32'(w_load);
      r_perf_wait  <= r_perf_wait + 32'(r_req && !imem_ack_i);
    end
  end
`endif
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: randomized self-checking bench for if_fetch with an in-bench memory, PC stage and reference model.
module tb_if_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_i = 32'h8000_0000;
  logic        ce_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        stall_req_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_valid_o;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetch_o;
  logic [31:0] perf_wait_o;
`endif
  if_fetch #(.NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .ce_i(ce_i), .flush_i(flush_i), .stall_i(stall_i),
    .stall_req_o(stall_req_o), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
    .id_pc_o(id_pc_o), .id_inst_o(id_inst_o), .id_valid_o(id_valid_o)
`ifdef IF_FETCH_PERF_EN
    , .perf_fetch_o(perf_fetch_o), .perf_wait_o(perf_wait_o)
`endif
  );
  always #5 clk = ~clk;
  int checks = 0;
  int fails = 0;
  // Reference: one outstanding read (possibly killed), one held word, one presented word.
  logic        m_req, m_killed, m_held, m_val;
  logic [31:0] m_addr, m_hpc, m_hinst, m_pc, m_inst, pc;
  int          wl, lat_lo, lat_hi, issued, sr_hi;
  logic [31:0] m_fetch, m_wait;
  logic        last_sr;
  logic [31:0] seen[$];
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5a5a_1234;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic model_reset();
    m_req = 0; m_killed = 0; m_held = 0; m_val = 0;
    m_addr = 32'h8000_0000; m_pc = 32'h8000_0000; m_inst = NOP;
    m_hpc = 0; m_hinst = 0; pc = 32'h8000_0000;
    wl = 0; issued = 0; m_fetch = 0; m_wait = 0;
  endtask
  task automatic do_reset();
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_addr", imem_addr_o, 32'h8000_0000);
    chk("rst_valid", 32'(id_valid_o), 32'd0);
    chk("rst_pc", id_pc_o, 32'h8000_0000);
    chk("rst_inst", id_inst_o, NOP);
    @(negedge clk);
    flush_i = 0; stall_i = 0; ce_i = 0; imem_ack_i = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask
  task automatic step(input logic f, input logic s, input logic c, input logic [31:0] tgt);
    logic ack, sreq;
    logic [31:0] rd;
    @(negedge clk);
    chk("imem_req", 32'(imem_req_o), 32'(m_req));
    chk("imem_addr", imem_addr_o, m_addr);
    chk("id_valid", 32'(id_valid_o), 32'(m_val));
    chk("id_pc", id_pc_o, m_pc);
    chk("id_inst", id_inst_o, m_inst);
    if (id_valid_o) begin
      seen.push_back(id_pc_o);
      chk("inst_vs_mem", id_inst_o, memf(id_pc_o));
    end
`ifdef IF_FETCH_PERF_EN
    chk("perf_fetch", perf_fetch_o, m_fetch);
    chk("perf_wait", perf_wait_o, m_wait);
`endif
    ack = m_req && wl == 0;
    rd = ack ? memf(m_addr) : $urandom;
    flush_i = f; stall_i = s; ce_i = c; pc_i = pc;
    imem_ack_i = ack; imem_rdata_i = rd;
    sreq = !f && (s || (m_req && (m_killed || !ack)) || m_held);
    #1 chk("stall_req", 32'(stall_req_o), 32'(sreq));
    last_sr = stall_req_o;
    if (stall_req_o) sr_hi++;
    @(posedge clk);
    if (m_req && !ack) begin
      m_wait++;
      wl--;
    end
    if (f) begin
      m_val = 0; m_inst = NOP; m_held = 0;
      if (m_req && !ack) m_killed = 1;
      else begin
        m_req = 0; m_killed = 0;
      end
    end else if (m_held) begin
      if (!s) begin
        m_val = 1; m_pc = m_hpc; m_inst = m_hinst; m_held = 0; m_fetch++;
      end
    end else if (m_killed) begin
      if (ack) begin
        m_req = 0; m_killed = 0;
      end
    end else if (m_req && !ack) begin
      if (!s) begin
        m_val = 0; m_inst = NOP;
      end
    end else if (ack && s) begin
      m_held = 1; m_hpc = m_addr; m_hinst = rd; m_req = 0;
    end else begin
      if (ack) begin
        m_val = 1; m_pc = m_addr; m_inst = rd; m_fetch++;
      end else if (!s) begin
        m_val = 0; m_inst = NOP;
      end
      m_req = 0;
      if (c && !s) begin
        m_req = 1; m_addr = pc; wl = int'($urandom_range(lat_hi, lat_lo)); issued++;
      end
    end
    if (f) pc = tgt;
    else if (!sreq && c) pc = pc + 32'd4;
  endtask
  initial begin
    int n10;
    model_reset();
    lat_lo = 0; lat_hi = 0;
    do_reset();
    // zero-wait streaming
    seen.delete(); sr_hi = 0;
    repeat (5) step(0, 0, 1, 0);
    chk("zw_count", seen.size(), 3);
    if (seen.size() >= 3) begin
      chk("zw_pc0", seen[0], 32'h8000_0000);
      chk("zw_pc1", seen[1], 32'h8000_0004);
      chk("zw_pc2", seen[2], 32'h8000_0008);
    end
    chk("zw_no_stall_req", sr_hi, 0);
    // two wait cycles
    do_reset();
    lat_lo = 2; lat_hi = 2;
    step(0, 0, 1, 0);
    seen.delete(); sr_hi = 0;
    repeat (5) step(0, 0, 0, 0);
    chk("w2_stall_cycles", sr_hi, 2);
    chk("w2_count", seen.size(), 1);
    if (seen.size() >= 1) chk("w2_pc", seen[0], 32'h8000_0000);
    // flush while waiting
    do_reset();
    lat_lo = 3; lat_hi = 3; pc = 32'h8000_0010;
    seen.delete();
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(1, 0, 1, 32'h8000_0100);
    chk("fl_stall_req_low", 32'(last_sr), 32'd0);
    repeat (10) step(0, 0, 1, 0);
    n10 = 0;
    foreach (seen[i]) if (seen[i] == 32'h8000_0010) n10++;
    chk("fl_killed_absent", n10, 0);
    chk("fl_count", seen.size(), 1);
    if (seen.size() >= 1) chk("fl_target", seen[0], 32'h8000_0100);
    // decode stall on ack
    do_reset();
    lat_lo = 1; lat_hi = 1; pc = 32'h8000_0020;
    seen.delete();
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    repeat (4) step(0, 1, 0, 0);
    chk("st_held", seen.size(), 0);
    chk("st_stall_req", 32'(last_sr), 32'd1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("st_count", seen.size(), 1);
    if (seen.size() >= 1) chk("st_pc", seen[0], 32'h8000_0020);
    // reset in the middle of a request
    do_reset();
    lat_lo = 3; lat_hi = 3;
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    do_reset();
    // randomized traffic
    lat_lo = 0; lat_hi = 3;
    for (int i = 0; i < 3000; i++)
      step($urandom_range(19, 0) == 0, $urandom_range(4, 0) == 0, $urandom_range(9, 0) != 0,
           $urandom & 32'hffff_fffc);
`ifdef IF_FETCH_PERF_EN
    do_reset();
    lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 40 && issued < 5; i++) step(0, 0, 1, 0);
    repeat (4) step(0, 0, 0, 0);
    chk("perf_fetch_5", perf_fetch_o, 32'd5);
    chk("perf_wait_5", perf_wait_o, 32'd5);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
